tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter BUSY_TMO, default 7, maximum cycles to wait for tx_busy to rise after tx_start.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, N_REQ bits: per-requester transmit request, level, held until ack.
REQ-006 SHALL have port req_word, input, N_REQ x 32 bits: per-requester payload, LSB byte sent first.
REQ-007 SHALL have port req_bytes, input, N_REQ x 3 bits: per-requester byte count.
REQ-008 SHALL have port ack, output, N_REQ bits: one-cycle pulse when a request is captured.
REQ-009 SHALL have port done, output, N_REQ bits: one-cycle pulse when that requester's transfer ends.
REQ-010 SHALL have port err, output, N_REQ bits: one-cycle pulse instead of done on busy timeout.
REQ-011 SHALL have port tx_start, output, 1 bit: start to the word transmitter.
REQ-012 SHALL have port tx_word, output, 32 bits, and port tx_bytes, output, 3 bits: the captured payload.
REQ-013 SHALL have port tx_busy, input, 1 bit: word transmitter busy.
REQ-014 SHALL have port owner, output, clog2(N_REQ) bits: index of the current or last granted requester.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: when any req is high and tx_busy is low, SHALL grant the first requester at or after rr_ptr (round-robin, wrapping), latch its word/bytes, pulse ack[i], and set owner.
REQ-017 IDLE with tx_busy high SHALL grant nothing.
REQ-018 SHALL clamp a latched req_bytes above 4 to 4.
REQ-019 A granted request with bytes = 0 SHALL pulse done[i] the cycle after ack and return to IDLE without asserting tx_start.
REQ-020 Otherwise, after the grant the state SHALL go to ISSUE, and tx_start SHALL be high exactly in ISSUE and in WAIT_BUSY.
REQ-021 WAIT_BUSY: tx_busy high SHALL drop tx_start and move the state to WAIT_DONE.
REQ-022 WAIT_BUSY: if tx_busy stays low for BUSY_TMO cycles, SHALL drop tx_start, pulse err[i], and return to IDLE.
REQ-023 WAIT_DONE: tx_busy low SHALL pulse done[i] and return to IDLE.
REQ-024 After each grant, rr_ptr SHALL become (granted index + 1) mod N_REQ.
REQ-025 tx_word and tx_bytes SHALL stay stable from grant until the transfer ends.
REQ-026 A req deasserted after ack SHALL NOT affect the transfer in progress.
REQ-027 Requests arriving during a transfer SHALL wait, with no loss.
REQ-028 ack, done and err SHALL each be at most one-hot per cycle.
REQ-029 Minimum grant-to-grant spacing SHALL be 4 cycles.

Reset
REQ-030 While rst_n is low, SHALL hold: state IDLE, rr_ptr 0, owner 0, and tx_start, ack, done, err all 0.
REQ-031 tx_word and tx_bytes SHALL reset to 0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no done or err pulse.

Structure
REQ-033 The state enum, BUSY_TMO default and MAX_BYTES = 4 SHALL live in shared package tx_pkg.
REQ-034 The round-robin pick SHALL be sub-module rr_pick (inputs req and ptr; outputs valid and idx).
REQ-035 The word transmitter SHALL NOT be instantiated inside this block; it is connected at the parent.

Verification
REQ-036 Single request: req[0], word 0x44332211, bytes 2 -> ack[0] in the grant cycle; tx_start for 1 cycle into a 1-cycle-latency transmitter model; done[0] after busy falls; tx_word 0x44332211.
REQ-037 Contention: req = 4'b1111 held, rr_ptr 0 -> grant order 0, 1, 2, 3, 0; each ack at least 4 cycles apart.
REQ-038 Zero/clamp: bytes 0 -> ack then done next cycle with tx_start never high; bytes 7 -> tx_bytes 4.
REQ-039 Timeout: transmitter model never asserts busy -> err[owner] pulses BUSY_TMO cycles after ISSUE, no done, tx_start low afterwards.
REQ-040 Reset mid-transfer: rst_n low in WAIT_DONE -> all outputs 0 immediately; after release, a pending req[2] is granted first with rr_ptr 0 (request 0 absent).

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and constants for the tx_arbiter block.
// Contents: state encoding, payload struct, byte-count limits, busy-timeout
// default, minimum grant spacing and the byte-count clamp helper.
package tx_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BYTES_W       = 3;
  localparam int unsigned MAX_BYTES     = 4;
  localparam int unsigned BUSY_TMO_DEF  = 7;
  localparam int unsigned MIN_GRANT_GAP = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Payload latched at grant and held for the whole transfer.
  typedef struct packed {
    logic [WORD_W-1:0]  word;
    logic [BYTES_W-1:0] bytes;
  } tx_payload_t;

  // A word carries at most MAX_BYTES bytes; larger counts are saturated.
  function automatic logic [BYTES_W-1:0] clamp_bytes(input logic [BYTES_W-1:0] b);
    return (b > BYTES_W'(MAX_BYTES)) ? BYTES_W'(MAX_BYTES) : b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first asserted request at or after ptr,
// wrapping around N_REQ.
// Ports: req   - request vector
//        ptr   - search start index
//        valid - any request found
//        idx   - index of the selected request (0 when none)
module rr_pick
  import tx_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] pos;

  // (p + k) mod N_REQ for k < N_REQ, without a divider.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = wrap_add(ptr, k);
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that hands one requester at a time to an external
// word transmitter and reports completion or busy-timeout per requester.
// Ports: clk, rst_n          - clock, async active-low reset
//        req/req_word/req_bytes - per-requester request level and payload
//        ack/done/err        - per-requester one-cycle pulses
//        tx_start/tx_word/tx_bytes - command to the word transmitter
//        tx_busy             - transmitter busy
//        owner               - current or last granted requester
module tx_arbiter
  import tx_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ-1:0][WORD_W-1:0]    req_word,
  input  logic [N_REQ-1:0][BYTES_W-1:0]   req_bytes,
  output logic [N_REQ-1:0]                ack,
  output logic [N_REQ-1:0]                done,
  output logic [N_REQ-1:0]                err,
  output logic                            tx_start,
  output logic [WORD_W-1:0]               tx_word,
  output logic [BYTES_W-1:0]              tx_bytes,
  input  logic                            tx_busy,
  output logic [$clog2(N_REQ)-1:0]        owner
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(BUSY_TMO);
  localparam int unsigned GW = $clog2(MIN_GRANT_GAP);

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    owner_d;
  tx_payload_t      pay_q, pay_d;
  logic [N_REQ-1:0] ack_d, done_d, err_d;
  logic             start_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             zdone_q, zdone_d;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             grant;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign tx_word  = pay_q.word;
  assign tx_bytes = pay_q.bytes;

  // Grants need an idle transmitter and an expired spacing window.
  assign grant = (state_q == IDLE) && pick_valid && !tx_busy && (gap_q == '0);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner;
    pay_d   = pay_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    tmo_d   = tmo_q;
    gap_d   = (gap_q != '0) ? gap_q - GW'(1) : '0;
    zdone_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Zero-byte grant completes one cycle after its ack.
        if (zdone_q) done_d[owner] = 1'b1;
        if (grant) begin
          ack_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          pay_d.word      = req_word[pick_idx];
          pay_d.bytes     = clamp_bytes(req_bytes[pick_idx]);
          rr_d            = (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + IW'(1);
          gap_d           = GW'(MIN_GRANT_GAP-1);
          tmo_d           = '0;
          if (req_bytes[pick_idx] == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = ISSUE;
            start_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        start_d = 1'b1;
        tmo_d   = tmo_q + TW'(1);
      end
      WAIT_BUSY: begin
        // The ISSUE cycle counts toward the busy timeout.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TMO-1)) begin
          err_d[owner] = 1'b1;
          state_d      = IDLE;
        end else begin
          start_d = 1'b1;
          tmo_d   = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_d[owner] = 1'b1;
          state_d       = IDLE;
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner    <= '0;
      pay_q    <= '0;
      ack      <= '0;
      done     <= '0;
      err      <= '0;
      tx_start <= 1'b0;
      tmo_q    <= '0;
      gap_q    <= '0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner    <= owner_d;
      pay_q    <= pay_d;
      ack      <= ack_d;
      done     <= done_d;
      err      <= err_d;
      tx_start <= start_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      zdone_q  <= zdone_d;
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a simple word-transmitter model.
module tb_tx_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0][31:0] req_word;
  logic [3:0][2:0]  req_bytes;
  logic [3:0]       ack, done, err;
  logic             tx_start;
  logic [31:0]      tx_word;
  logic [2:0]       tx_bytes;
  logic             tx_busy;
  logic [1:0]       owner;

  // Transmitter model: busy rises the edge after tx_start, lasts hold+1 cycles.
  logic             busy_m;
  logic             busy_f;
  logic             xmit_en;
  int unsigned      hold;
  int unsigned      hold_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  assign tx_busy = busy_m | busy_f;

  tx_arbiter #(.N_REQ(4), .BUSY_TMO(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_word  (req_word),
    .req_bytes (req_bytes),
    .ack       (ack),
    .done      (done),
    .err       (err),
    .tx_start  (tx_start),
    .tx_word   (tx_word),
    .tx_bytes  (tx_bytes),
    .tx_busy   (tx_busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m   <= 1'b0;
      hold_cnt <= 0;
    end else if (busy_m) begin
      if (hold_cnt == 0) busy_m <= 1'b0;
      else hold_cnt <= hold_cnt - 1;
    end else if (tx_start && xmit_en) begin
      busy_m   <= 1'b1;
      hold_cnt <= hold;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 20);
    chk({tag, " ack seen"}, 32'(ack != '0), 32'd1);
  endtask

  task automatic wait_fin(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((done | err) == '0 && n < 30);
    chk({tag, " end seen"}, 32'((done | err) != '0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ng, last, idx;
    logic [3:0] acc;

    rst_n     = 1'b0;
    req       = '0;
    req_word  = '0;
    req_bytes = '0;
    busy_f    = 1'b0;
    xmit_en   = 1'b1;
    hold      = 0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst tx_start", 32'(tx_start), 32'd0);
    chk("rst owner", 32'(owner), 32'd0);
    chk("rst tx_word", tx_word, 32'd0);
    chk("rst tx_bytes", 32'(tx_bytes), 32'd0);
    rst_n = 1'b1;

    // Single request, 1-cycle-latency transmitter
    req_word[0]  = 32'h44332211;
    req_bytes[0] = 3'd2;
    req          = 4'b0001;
    @(negedge clk);
    chk("single ack", 32'(ack), 32'h1);
    chk("single start issue", 32'(tx_start), 32'd1);
    chk("single owner", 32'(owner), 32'd0);
    chk("single word", tx_word, 32'h44332211);
    chk("single bytes", 32'(tx_bytes), 32'd2);
    req         = '0;
    req_word[0] = 32'h0;
    @(negedge clk);
    chk("single start wait_busy", 32'(tx_start), 32'd1);
    chk("single ack pulse", 32'(ack), 32'd0);
    @(negedge clk);
    chk("single start dropped", 32'(tx_start), 32'd0);
    chk("single no early done", 32'(done), 32'd0);
    chk("single word stable", tx_word, 32'h44332211);
    @(negedge clk);
    chk("single done", 32'(done), 32'h1);
    chk("single no err", 32'(err), 32'd0);
    @(negedge clk);
    chk("single done pulse", 32'(done), 32'd0);

    // Contention: all four held from rr_ptr 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_word[i]  = 32'h1000 + 32'(i);
      req_bytes[i] = 3'd1;
    end
    req  = 4'b1111;
    ng   = 0;
    last = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (done != '0) chk("cont done onehot", 32'((done & (done - 4'd1)) == '0), 32'd1);
      if (ack != '0 && ng < 5) begin
        chk("cont ack onehot", 32'((ack & (ack - 4'd1)) == '0), 32'd1);
        idx = oh_idx(ack);
        chk($sformatf("cont order %0d", ng), 32'(idx), 32'(exp_ord[ng]));
        chk($sformatf("cont owner %0d", ng), 32'(owner), 32'(exp_ord[ng]));
        chk($sformatf("cont word %0d", ng), tx_word, 32'h1000 + 32'(exp_ord[ng]));
        if (ng > 0) chk($sformatf("cont spacing %0d", ng), 32'((cyc - last) >= 4), 32'd1);
        last = cyc;
        ng++;
      end
    end
    chk("cont grant count", 32'(ng), 32'd5);
    req = '0;

    // Zero-byte grant, then a clamped byte count
    do_reset();
    req_bytes[1] = 3'd0;
    req          = 4'b0010;
    @(negedge clk);
    chk("zero ack", 32'(ack), 32'h2);
    chk("zero no start a", 32'(tx_start), 32'd0);
    req = '0;
    @(negedge clk);
    chk("zero done", 32'(done), 32'h2);
    chk("zero no start b", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("zero done pulse", 32'(done), 32'd0);
    chk("zero no start c", 32'(tx_start), 32'd0);
    req_word[3]  = 32'hDEADBEEF;
    req_bytes[3] = 3'd7;
    req          = 4'b1000;
    wait_ack("clamp");
    chk("clamp ack", 32'(ack), 32'h8);
    chk("clamp owner", 32'(owner), 32'd3);
    chk("clamp bytes", 32'(tx_bytes), 32'd4);
    chk("clamp word", tx_word, 32'hDEADBEEF);
    req = '0;
    wait_fin("clamp");
    chk("clamp done", 32'(done), 32'h8);

    // Busy high while idle blocks grants
    do_reset();
    busy_f = 1'b1;
    req    = 4'b0001;
    acc    = '0;
    repeat (6) begin
      @(negedge clk);
      acc = acc | ack;
    end
    chk("busy blocks grant", 32'(acc), 32'd0);
    busy_f = 1'b0;
    wait_ack("busy release");
    chk("busy release ack", 32'(ack), 32'h1);
    req = '0;
    wait_fin("busy release");

    // Busy timeout
    do_reset();
    xmit_en      = 1'b0;
    req_bytes[2] = 3'd3;
    req          = 4'b0100;
    wait_ack("tmo");
    chk("tmo start in issue", 32'(tx_start), 32'd1);
    req = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) begin
        chk("tmo start before", 32'(tx_start), 32'd1);
        chk("tmo no early err", 32'(err), 32'd0);
      end else if (k == 7) begin
        chk("tmo err", 32'(err), 32'h4);
        chk("tmo no done", 32'(done), 32'd0);
        chk("tmo start dropped", 32'(tx_start), 32'd0);
      end else if (k == 8) begin
        chk("tmo err pulse", 32'(err), 32'd0);
        chk("tmo start low", 32'(tx_start), 32'd0);
      end
    end
    xmit_en = 1'b1;

    // Reset while in WAIT_DONE
    do_reset();
    hold         = 5;
    req_word[2]  = 32'hA5A5A5A5;
    req_bytes[2] = 3'd2;
    req          = 4'b0100;
    wait_ack("mid");
    req = '0;
    repeat (2) @(negedge clk);
    chk("mid in wait_done start", 32'(tx_start), 32'd0);
    chk("mid in wait_done busy", 32'(tx_busy), 32'd1);
    req_word[2] = 32'h22222222;
    req_word[3] = 32'h33333333;
    req         = 4'b1100;
    rst_n       = 1'b0;
    #1;
    chk("mid rst ack", 32'(ack), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst err", 32'(err), 32'd0);
    chk("mid rst start", 32'(tx_start), 32'd0);
    chk("mid rst owner", 32'(owner), 32'd0);
    chk("mid rst word", tx_word, 32'd0);
    chk("mid rst bytes", 32'(tx_bytes), 32'd0);
    acc = '0;
    repeat (2) begin
      @(negedge clk);
      acc = acc | done | err;
    end
    chk("mid rst no end pulse", 32'(acc), 32'd0);
    rst_n = 1'b1;
    wait_ack("mid regrant");
    chk("mid regrant ack", 32'(ack), 32'h4);
    chk("mid regrant owner", 32'(owner), 32'd2);
    chk("mid regrant word", tx_word, 32'h22222222);
    req = '0;
    wait_fin("mid regrant");
    chk("mid regrant done", 32'(done), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
